// File: rtl/lift_sequencer.sv
// lift_sequencer
//   Walks one line of samples held in single-port RAM and feeds each sample
//   with its two (mirrored) neighbours to an external lifting unit, then
//   writes the lifting result back to a destination buffer.  Samples are
//   handled strictly one at a time: read L, S, R -> present to lifter ->
//   write result, so overlapping source/destination ranges behave in order.
//
//   Per sample: FETCH (3 + RD_LAT) + CALC (JPEG_LAT) + WR (1) cycles.
//
// Parameters
//   RD_LAT    cycles from ram_addr issue to valid ram_data_out
//   JPEG_LAT  cycles from stable l_s/s_s/r_s to valid res_s (>= 1)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle request (ignored while busy)
//   f_i, e_o             forward/inverse, even/odd select (latched at start)
//   src_addr, dst_addr   source / destination base word addresses
//   count                samples in the line (0 -> immediate done)
//   abort                only with LIFT_SEQ_ABORT_EN: stop the line early
//   busy, done           status; done is a one-cycle pulse
//   ram_addr, ram_data_in, ram_wren, ram_data_out   SPRAM master port
//   l_s, s_s, r_s, e_o_s, f_i_s, res_s              lifting-unit port
//
// Optional feature macro: LIFT_SEQ_ABORT_EN
module lift_sequencer #(
  parameter int RD_LAT   = 2,
  parameter int JPEG_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               f_i,
  input  logic               e_o,
  input  logic [15:0]        src_addr,
  input  logic [15:0]        dst_addr,
  input  logic [15:0]        count,
`ifdef LIFT_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [15:0]        ram_addr,
  output logic [15:0]        ram_data_in,
  output logic               ram_wren,
  input  logic [15:0]        ram_data_out,
  output logic signed [15:0] l_s,
  output logic signed [15:0] s_s,
  output logic signed [15:0] r_s,
  output logic               e_o_s,
  output logic               f_i_s,
  input  logic signed [15:0] res_s
);

  // Phase-counter values: reads issue at phases 0,1,2 and each word is
  // captured RD_LAT phases later, so R lands on the last FETCH phase.
  localparam logic [15:0] CAP_L      = 16'(RD_LAT);
  localparam logic [15:0] CAP_S      = 16'(RD_LAT + 1);
  localparam logic [15:0] FETCH_LAST = 16'(RD_LAT + 2);
  localparam logic [15:0] CALC_LAST  = 16'(JPEG_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, WR, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        i_q, i_d;
  logic [15:0]        ph_q, ph_d;
  logic signed [15:0] l_s_q, l_s_d, s_s_q, s_s_d, r_s_q, r_s_d;
  logic               e_o_s_q, e_o_s_d, f_i_s_q, f_i_s_d;

  // Line configuration and the first two fetched words; these are only
  // consumed after being written, so they carry no reset.
  logic [15:0]        src_q, dst_q, num_q;
  logic               fi_q, eo_q;
  logic [15:0]        l_q, s_q;

  logic               cfg_load;
  logic               present;
  logic [15:0]        last_idx, nb_l, nb_r;

  // Symmetric mirror at both line ends; a single-sample line mirrors onto
  // itself.
  always_comb begin
    last_idx = num_q - 16'd1;
    nb_l     = (i_q != 16'd0) ? i_q - 16'd1 : ((num_q > 16'd1) ? 16'd1 : 16'd0);
    nb_r     = (i_q < last_idx) ? i_q + 16'd1
             : ((num_q > 16'd1) ? i_q - 16'd1 : 16'd0);
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    ph_d     = ph_q;
    cfg_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != 16'd0) begin
            cfg_load = 1'b1;
            i_d      = 16'd0;
            ph_d     = 16'd0;
            state_d  = FETCH;
          end else begin
            state_d  = DONE;
          end
        end
      end
      FETCH: begin
        if (ph_q == FETCH_LAST) begin
          ph_d    = 16'd0;
          state_d = CALC;
        end else begin
          ph_d    = ph_q + 16'd1;
        end
      end
      CALC: begin
        if (ph_q == CALC_LAST) begin
          ph_d    = 16'd0;
          state_d = WR;
        end else begin
          ph_d    = ph_q + 16'd1;
        end
      end
      WR: begin
        ph_d = 16'd0;
        if (i_q == last_idx) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 16'd1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LIFT_SEQ_ABORT_EN
    // An in-flight write is always allowed to finish; abort only cuts
    // FETCH/CALC short.
    if (abort && (state_q == FETCH || state_q == CALC)) begin
      state_d = DONE;
    end
`endif
  end

  // Lifter inputs change only on the FETCH->CALC edge, so they are stable
  // through CALC and hold their value everywhere else.
  always_comb begin
    present = (state_q == FETCH) && (state_d == CALC);
    l_s_d   = l_s_q;
    s_s_d   = s_s_q;
    r_s_d   = r_s_q;
    e_o_s_d = e_o_s_q;
    f_i_s_d = f_i_s_q;
    if (present) begin
      l_s_d   = $signed(l_q);
      s_s_d   = $signed(s_q);
      r_s_d   = $signed(ram_data_out);
      e_o_s_d = eo_q;
      f_i_s_d = fi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 16'd0;
      ph_q    <= 16'd0;
      l_s_q   <= '0;
      s_s_q   <= '0;
      r_s_q   <= '0;
      e_o_s_q <= 1'b0;
      f_i_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      ph_q    <= ph_d;
      l_s_q   <= l_s_d;
      s_s_q   <= s_s_d;
      r_s_q   <= r_s_d;
      e_o_s_q <= e_o_s_d;
      f_i_s_q <= f_i_s_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_load) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      num_q <= count;
      fi_q  <= f_i;
      eo_q  <= e_o;
    end
    if (state_q == FETCH && ph_q == CAP_L) l_q <= ram_data_out;
    if (state_q == FETCH && ph_q == CAP_S) s_q <= ram_data_out;
  end

  // RAM port is decoded from state so reset clears it immediately.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    ram_wren    = (state_q == WR);
    ram_addr    = 16'd0;
    ram_data_in = 16'd0;
    if (state_q == FETCH) begin
      case (ph_q)
        16'd0:   ram_addr = src_q + nb_l;
        16'd1:   ram_addr = src_q + i_q;
        16'd2:   ram_addr = src_q + nb_r;
        default: ram_addr = 16'd0;
      endcase
    end else if (state_q == WR) begin
      ram_addr    = dst_q + i_q;
      ram_data_in = $unsigned(res_s);
    end
  end

  assign l_s   = l_s_q;
  assign s_s   = s_s_q;
  assign r_s   = r_s_q;
  assign e_o_s = e_o_s_q;
  assign f_i_s = f_i_s_q;

endmodule

// File: tb/tb_lift_sequencer.sv
// Bench for lift_sequencer: SPRAM and lifting-unit behavioural models, a
// line-level reference model feeding an expected-write queue, and a monitor
// that checks every DUT write against that queue.
module tb_lift_sequencer;
  localparam int RD_LAT   = 2;
  localparam int JPEG_LAT = 1;
  localparam int C        = 4 + RD_LAT + JPEG_LAT;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               f_i, e_o;
  logic [15:0]        src_addr, dst_addr, count;
  logic               busy, done;
  logic [15:0]        ram_addr, ram_data_in, ram_data_out;
  logic               ram_wren;
  logic signed [15:0] l_s, s_s, r_s, res_s;
  logic               e_o_s, f_i_s;
`ifdef LIFT_SEQ_ABORT_EN
  logic               abort;
`endif

  lift_sequencer #(.RD_LAT(RD_LAT), .JPEG_LAT(JPEG_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .f_i(f_i), .e_o(e_o),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
`ifdef LIFT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_wren(ram_wren), .ram_data_out(ram_data_out),
    .l_s(l_s), .s_s(s_s), .r_s(r_s), .e_o_s(e_o_s), .f_i_s(f_i_s),
    .res_s(res_s)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;
  int done_seen = 0;

  typedef struct {
    logic [15:0]        addr;
    logic [15:0]        data;
    logic signed [15:0] l, s, r;
  } exp_t;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] old;
  } undo_t;

  exp_t  exp_q[$];
  undo_t undo_q[$];

  logic [15:0]        mem     [65536];
  logic [15:0]        ref_mem [65536];
  logic [15:0]        rd_pipe [RD_LAT];
  logic signed [15:0] jp      [JPEG_LAT];

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Stand-in lifting step: predict from the neighbour average.
  function automatic logic signed [15:0] lift(input logic signed [15:0] l, s, r,
                                              input logic eo, fi);
    logic signed [16:0] sum, p;
    sum = l + r;
    p   = eo ? (sum >>> 1) : ((sum + 17'sd2) >>> 2);
    return fi ? s - p[15:0] : s + p[15:0];
  endfunction

  // SPRAM: registered read with RD_LAT cycles of latency, write on WR.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] = ram_data_in;
    rd_pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_data_out = rd_pipe[RD_LAT-1];

  // Lifting unit: result valid JPEG_LAT cycles after stable inputs.
  always @(posedge clk) begin
    jp[0] <= lift(l_s, s_s, r_s, e_o_s, f_i_s);
    for (int k = 1; k < JPEG_LAT; k++) jp[k] <= jp[k-1];
  end
  assign res_s = jp[JPEG_LAT-1];

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (done) done_seen++;
    if (ram_wren) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", ram_addr, e.addr);
        chk("wr_data", ram_data_in, e.data);
        chk("lift_triple", {l_s, s_s, r_s}, {e.l, e.s, e.r});
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // Reference: process the line sample by sample on the model memory.
  task automatic model_line(input logic [15:0] src, dst, cnt,
                            input logic fi, eo);
    exp_t  e;
    undo_t u;
    int    n, lk, rk;
    n = int'(cnt);
    undo_q.delete();
    for (int k = 0; k < n; k++) begin
      lk = (k > 0) ? k - 1 : ((n > 1) ? 1 : 0);
      rk = (k < n - 1) ? k + 1 : ((n > 1) ? k - 1 : 0);
      e.l    = $signed(ref_mem[src + 16'(lk)]);
      e.s    = $signed(ref_mem[src + 16'(k)]);
      e.r    = $signed(ref_mem[src + 16'(rk)]);
      e.data = lift(e.l, e.s, e.r, eo, fi);
      e.addr = dst + 16'(k);
      u.addr = e.addr;
      u.old  = ref_mem[e.addr];
      undo_q.push_back(u);
      ref_mem[e.addr] = e.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic keep_writes(input int keep);
    for (int j = undo_q.size() - 1; j >= keep; j--)
      ref_mem[undo_q[j].addr] = undo_q[j].old;
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctrl"}, {busy, done, ram_wren, e_o_s, f_i_s, ram_addr, ram_data_in}, 0);
    chk({nm, "_lift"}, {l_s, s_s, r_s}, 0);
  endtask

  // mode 0: normal (with an ignored start mid-line), 1: reset at ev, 2: abort at ev
  task automatic run_op(input logic [15:0] src, dst, cnt, input logic fi, eo,
                        input int mode, input int ev);
    int cyc, exp_lat, keep;
    bit got, busy_drop;
    model_line(src, dst, cnt, fi, eo);
    writes_seen = 0;
    done_seen   = 0;
    exp_lat     = 1 + int'(cnt) * C;
    got         = 0;
    busy_drop   = 0;
    @(negedge clk);
    src_addr = src; dst_addr = dst; count = cnt; f_i = fi; e_o = eo; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < exp_lat + 40) begin
      if (done) begin got = 1; break; end
      if (!busy) busy_drop = 1;
      if (mode == 1 && cyc == ev) break;
      if (mode == 0 && cyc == 3) begin
        start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom);
        count = 16'($urandom_range(0, 5)); f_i = ~fi;
      end
`ifdef LIFT_SEQ_ABORT_EN
      if (mode == 2 && cyc == ev) abort = 1'b1;
`endif
      @(negedge clk);
      cyc++;
      start = 1'b0;
`ifdef LIFT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
    end
    chk("busy_held", busy_drop, 0);
    if (mode == 1) begin
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3 * C) @(negedge clk);
      chk("reset_writes", writes_seen, 1);
      chk("reset_no_done", done_seen, 0);
      keep_writes(1);
    end else begin
      keep = (mode == 2) ? 2 : int'(cnt);
      chk("done_latency", got ? cyc : -1, (mode == 2) ? ev + 1 : exp_lat);
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      chk("after_done", {done, busy}, 0);
      chk("write_count", writes_seen, keep);
      chk("done_pulses", done_seen, 1);
      chk("queue_left", exp_q.size(), (mode == 2) ? int'(cnt) - 2 : 0);
      keep_writes(keep);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int diffs;
    logic [15:0] s, d, c;
    rst = 1'b1; start = 1'b0; f_i = 1'b0; e_o = 1'b0;
    src_addr = 16'd0; dst_addr = 16'd0; count = 16'd0;
`ifdef LIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) poke(16'(a), 16'($urandom));
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst = 1'b0;

    poke(16'h0000, 16'd10); poke(16'h0001, 16'd20);
    poke(16'h0002, 16'd30); poke(16'h0003, 16'd40);
    run_op(16'h0000, 16'h0100, 16'd4, 1'b0, 1'b0, 0, 0);

    poke(16'h0200, 16'd55);
    run_op(16'h0200, 16'h0300, 16'd1, 1'b1, 1'b0, 0, 0);

    run_op(16'h0800, 16'h0900, 16'd0, 1'b0, 1'b1, 0, 0);

    poke(16'hFFFE, 16'd111); poke(16'hFFFF, 16'd222); poke(16'h0000, 16'd333);
    run_op(16'hFFFE, 16'h0400, 16'd3, 1'b0, 1'b1, 0, 0);

    run_op(16'h0500, 16'h0600, 16'd4, 1'b1, 1'b1, 1, 1 + C + 3 + RD_LAT);
    run_op(16'h0500, 16'h0600, 16'd4, 1'b1, 1'b1, 0, 0);

`ifdef LIFT_SEQ_ABORT_EN
    run_op(16'h0700, 16'h0A00, 16'd4, 1'b0, 1'b0, 2, 1 + 2 * C + 1);
`endif

    for (int t = 0; t < 8; t++) begin
      s = 16'($urandom);
      c = 16'($urandom_range(1, 8));
      d = (t % 3 == 0) ? s + 16'($urandom_range(0, 3)) : 16'($urandom);
      run_op(s, d, c, 1'($urandom), 1'($urandom), 0, 0);
    end

    diffs = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) diffs++;
    chk("final_memory", diffs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
